// File: rtl/i2c_pkg.sv
// Engine command codes and sequencer state encodings shared by the sequencer
// and the bit-level I2C engine.
package i2c_pkg;

  typedef enum logic [2:0] {
    CMD_GET       = 3'd0,
    CMD_START     = 3'd1,
    CMD_SEND_ONE  = 3'd2,
    CMD_RSTART    = 3'd3,
    CMD_STOP      = 3'd4,
    CMD_SEND_BYTE = 3'd5,
    CMD_RECV_BYTE = 3'd6,
    CMD_SEND_ZERO = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DEV_W,
    ST_REG,
    ST_WR_BYTE,
    ST_RSTART,
    ST_DEV_R,
    ST_RECV,
    ST_ACK,
    ST_STOP,
    ST_FAIL_STOP
  } seq_state_e;

  localparam int DEF_MAX_BYTES = 4;
  localparam int DEF_CNT_W     = 3;
  localparam int DEF_RETRY_MAX = 2;

  // The ACK step sends NACK (SEND_ONE) after the last byte, ACK (SEND_ZERO) otherwise.
  function automatic cmd_e state_cmd(input seq_state_e s, input logic last_byte);
    cmd_e c;
    case (s)
      ST_START:                                   c = CMD_START;
      ST_DEV_W, ST_REG, ST_WR_BYTE, ST_DEV_R:     c = CMD_SEND_BYTE;
      ST_RSTART:                                  c = CMD_RSTART;
      ST_RECV:                                    c = CMD_RECV_BYTE;
      ST_ACK:                                     c = last_byte ? CMD_SEND_ONE : CMD_SEND_ZERO;
      ST_STOP, ST_FAIL_STOP:                      c = CMD_STOP;
      default:                                    c = CMD_GET;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i2c_seq_ctrl_if.sv
// Host request/status and bit-engine command signals of the I2C sequencer.
interface i2c_seq_ctrl_if #(
  parameter int MAX_BYTES = 4,
  parameter int CNT_W     = 3
);
  logic                   start;
  logic                   rw;
  logic [6:0]             dev_addr;
  logic [7:0]             reg_addr;
  logic [CNT_W-1:0]       byte_count;
  logic [8*MAX_BYTES-1:0] wr_data;
  logic                   req_next;
  logic                   ack_failed;
  logic                   rx_valid;
  logic [7:0]             rx_byte;
  logic [2:0]             send_next_state;
  logic [7:0]             send_byte_data;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [8*MAX_BYTES-1:0] rd_data;

  modport master (
    input  start, rw, dev_addr, reg_addr, byte_count, wr_data,
    input  req_next, ack_failed, rx_valid, rx_byte,
    output send_next_state, send_byte_data, busy, done, error, rd_data
  );

  modport slave (
    output start, rw, dev_addr, reg_addr, byte_count, wr_data,
    output req_next, ack_failed, rx_valid, rx_byte,
    input  send_next_state, send_byte_data, busy, done, error, rd_data
  );
endinterface

// File: rtl/i2c_byte_buf.sv
// Write-byte latch and read-byte capture lanes, each addressed by a byte index.
module i2c_byte_buf #(
  parameter int MAX_BYTES = 4,
  parameter int IDX_W     = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [8*MAX_BYTES-1:0] wr_data_in,
  input  logic [IDX_W-1:0]       wr_sel,
  output logic [7:0]             wr_byte,
  input  logic                   capture,
  input  logic [IDX_W-1:0]       rd_sel,
  input  logic [7:0]             rx_byte,
  output logic [8*MAX_BYTES-1:0] rd_data
);
  logic [8*MAX_BYTES-1:0] wr_flat;

  generate
    for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
      logic [7:0] wr_lane_reg;
      logic [7:0] rd_lane_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          wr_lane_reg <= '0;
          rd_lane_reg <= '0;
        end else begin
          if (load)
            wr_lane_reg <= wr_data_in[8*gi +: 8];
          if (capture && (rd_sel == IDX_W'(gi)))
            rd_lane_reg <= rx_byte;
        end
      end

      assign wr_flat[8*gi +: 8] = wr_lane_reg;
      assign rd_data[8*gi +: 8] = rd_lane_reg;
    end
  endgenerate

  always_comb begin
    wr_byte = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (wr_sel == IDX_W'(i))
        wr_byte = wr_flat[8*i +: 8];
  end
endmodule

// File: rtl/i2c_seq_ctrl.sv
// Multi-byte I2C transaction sequencer: steps the bit engine through burst
// read/write command sequences with bounded retry on NACK.
module i2c_seq_ctrl
  import i2c_pkg::*;
#(
  parameter int MAX_BYTES = DEF_MAX_BYTES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RETRY_MAX = DEF_RETRY_MAX
) (
  input logic          clock,
  input logic          reset,
  i2c_seq_ctrl_if.master bus
);
  localparam int               RTY_W   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  seq_state_e       state_reg, state_next;
  logic [CNT_W-1:0] idx_reg, idx_next, count_reg, count_clamped;
  logic [RTY_W-1:0] retry_reg, retry_next;
  logic             rw_reg;
  logic [6:0]       dev_reg;
  logic [7:0]       reg_addr_reg;
  logic [2:0]       cmd_reg;
  logic [7:0]       byte_reg, byte_next, wr_byte;
  logic             busy_reg, done_reg, error_reg, done_next, error_next;
  logic             accept, last_cur, last_next;

  assign accept    = (state_reg == ST_IDLE) && bus.start;
  assign last_cur  = (idx_reg == count_reg - 1'b1);
  assign last_next = (idx_next == count_reg - 1'b1);

  // Reads always move at least one byte; both directions are capped at the buffer size.
  always_comb begin
    count_clamped = bus.byte_count;
    if (bus.byte_count > MAX_CNT)
      count_clamped = MAX_CNT;
    if (bus.rw && (bus.byte_count == '0))
      count_clamped = CNT_W'(1);
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    retry_next = retry_reg;
    done_next  = 1'b0;
    error_next = 1'b0;
    if (accept) begin
      state_next = ST_START;
      retry_next = '0;
    end else if ((state_reg != ST_IDLE) && (state_reg != ST_FAIL_STOP) && bus.ack_failed) begin
      state_next = ST_FAIL_STOP;
    end else if (bus.req_next) begin
      case (state_reg)
        ST_START: begin
          state_next = ST_DEV_W;
          idx_next   = '0;
        end
        ST_DEV_W:  state_next = ST_REG;
        ST_REG: begin
          if (rw_reg)
            state_next = ST_RSTART;
          else if (count_reg == '0)
            state_next = ST_STOP;
          else
            state_next = ST_WR_BYTE;
        end
        ST_WR_BYTE: begin
          if (last_cur) begin
            state_next = ST_STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
        ST_RSTART: state_next = ST_DEV_R;
        ST_DEV_R:  state_next = ST_RECV;
        ST_RECV:   state_next = ST_ACK;
        ST_ACK: begin
          if (last_cur) begin
            state_next = ST_STOP;
          end else begin
            state_next = ST_RECV;
            idx_next   = idx_reg + 1'b1;
          end
        end
        ST_STOP: begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
        ST_FAIL_STOP: begin
          if (retry_reg == RTY_W'(RETRY_MAX)) begin
            state_next = ST_IDLE;
            error_next = 1'b1;
          end else begin
            state_next = ST_START;
            retry_next = retry_reg + 1'b1;
          end
        end
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_next = '0;
    case (state_next)
      ST_DEV_W:   byte_next = {dev_reg, 1'b0};
      ST_REG:     byte_next = reg_addr_reg;
      ST_WR_BYTE: byte_next = wr_byte;
      ST_DEV_R:   byte_next = {dev_reg, 1'b1};
      default:    byte_next = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      retry_reg    <= '0;
      count_reg    <= '0;
      rw_reg       <= 1'b0;
      dev_reg      <= '0;
      reg_addr_reg <= '0;
      cmd_reg      <= CMD_GET;
      byte_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      retry_reg <= retry_next;
      cmd_reg   <= state_cmd(state_next, last_next);
      byte_reg  <= byte_next;
      busy_reg  <= (state_next != ST_IDLE);
      done_reg  <= done_next;
      error_reg <= error_next;
      if (accept) begin
        rw_reg       <= bus.rw;
        dev_reg      <= bus.dev_addr;
        reg_addr_reg <= bus.reg_addr;
        count_reg    <= count_clamped;
      end
    end
  end

  i2c_byte_buf #(
    .MAX_BYTES (MAX_BYTES),
    .IDX_W     (CNT_W)
  ) u_byte_buf (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .wr_data_in (bus.wr_data),
    .wr_sel     (idx_next),
    .wr_byte    (wr_byte),
    .capture    ((state_reg == ST_RECV) && bus.rx_valid),
    .rd_sel     (idx_reg),
    .rx_byte    (bus.rx_byte),
    .rd_data    (bus.rd_data)
  );

  assign bus.send_next_state = cmd_reg;
  assign bus.send_byte_data  = byte_reg;
  assign bus.busy            = busy_reg;
  assign bus.done            = done_reg;
  assign bus.error           = error_reg;
endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Directed bench for i2c_seq_ctrl: an engine stand-in pulses req_next/ack_failed
// and feeds bytes, each command step compared against hand-computed codes.
module tb_i2c_seq_ctrl;
  import i2c_pkg::*;

  localparam int MB = 4;
  localparam int CW = 3;
  localparam int RM = 2;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   both_cnt = 0;
  int   done_snap, err_snap;

  always #5 clock = ~clock;

  i2c_seq_ctrl_if #(.MAX_BYTES(MB), .CNT_W(CW)) bus ();

  i2c_seq_ctrl #(.MAX_BYTES(MB), .CNT_W(CW), .RETRY_MAX(RM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clock) begin
    if (bus.done)  done_cnt++;
    if (bus.error) err_cnt++;
    if (bus.done && bus.error) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input string tag, input logic r, input logic [6:0] d, input logic [7:0] ra,
                          input logic [2:0] n, input logic [31:0] wd);
    bus.start = 1'b1; bus.rw = r; bus.dev_addr = d; bus.reg_addr = ra;
    bus.byte_count = n; bus.wr_data = wd;
    tick();
    bus.start = 1'b0;
    $display("txn %s: rw=%0d dev=0x%0h reg=0x%0h n=%0d", tag, r, d, ra, n);
    check({tag, "_start_code"}, 32'(bus.send_next_state), 32'(CMD_START));
    check({tag, "_start_busy"}, 32'(bus.busy), 32'd1);
  endtask

  // Two idle cycles then a one-cycle req_next/ack_failed pulse; outputs sampled right after.
  task automatic step(input string tag, input logic rq, input logic af, input cmd_e ec, input logic [7:0] eb);
    tick(); tick();
    bus.req_next = rq; bus.ack_failed = af;
    tick();
    bus.req_next = 1'b0; bus.ack_failed = 1'b0;
    check({tag, "_code"}, 32'(bus.send_next_state), 32'(ec));
    check({tag, "_byte"}, 32'(bus.send_byte_data), 32'(eb));
  endtask

  task automatic feed_rx(input logic [7:0] b);
    bus.rx_valid = 1'b1; bus.rx_byte = b;
    tick();
    bus.rx_valid = 1'b0; bus.rx_byte = 8'h00;
  endtask

  task automatic expect_done(input string tag);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_err_low"}, 32'(bus.error), 32'd0);
    check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.start = 0; bus.rw = 0; bus.dev_addr = 0; bus.reg_addr = 0; bus.byte_count = 0;
    bus.wr_data = 0; bus.req_next = 0; bus.ack_failed = 0; bus.rx_valid = 0; bus.rx_byte = 0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_code", 32'(bus.send_next_state), 32'(CMD_GET));
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rd", bus.rd_data, 32'h0);

    // Burst write with a start issued mid-transaction that must be ignored.
    do_start("wr2", 1'b0, 7'h1A, 8'h05, 3'd2, 32'h0000_4433);
    step("wr2_dev", 1, 0, CMD_SEND_BYTE, 8'h34);
    bus.start = 1'b1; bus.rw = 1'b1; bus.dev_addr = 7'h55; bus.reg_addr = 8'hAA;
    bus.byte_count = 3'd1; bus.wr_data = 32'hFFFF_FFFF;
    tick();
    bus.start = 1'b0;
    check("busy_start_code", 32'(bus.send_next_state), 32'(CMD_SEND_BYTE));
    check("busy_start_byte", 32'(bus.send_byte_data), 32'h34);
    step("wr2_reg", 1, 0, CMD_SEND_BYTE, 8'h05);
    step("wr2_d0", 1, 0, CMD_SEND_BYTE, 8'h33);
    step("wr2_d1", 1, 0, CMD_SEND_BYTE, 8'h44);
    step("wr2_stop", 1, 0, CMD_STOP, 8'h00);
    step("wr2_end", 1, 0, CMD_GET, 8'h00);
    expect_done("wr2");

    // Burst read of three bytes; a stray rx_valid outside RECV must not be captured.
    do_start("rd3", 1'b1, 7'h1D, 8'h32, 3'd3, 32'h0);
    step("rd3_devw", 1, 0, CMD_SEND_BYTE, 8'h3A);
    step("rd3_reg", 1, 0, CMD_SEND_BYTE, 8'h32);
    step("rd3_rs", 1, 0, CMD_RSTART, 8'h00);
    step("rd3_devr", 1, 0, CMD_SEND_BYTE, 8'h3B);
    step("rd3_r0", 1, 0, CMD_RECV_BYTE, 8'h00);
    feed_rx(8'hA1);
    step("rd3_a0", 1, 0, CMD_SEND_ZERO, 8'h00);
    feed_rx(8'hEE);
    step("rd3_r1", 1, 0, CMD_RECV_BYTE, 8'h00);
    feed_rx(8'hB2);
    step("rd3_a1", 1, 0, CMD_SEND_ZERO, 8'h00);
    step("rd3_r2", 1, 0, CMD_RECV_BYTE, 8'h00);
    feed_rx(8'hC3);
    step("rd3_a2", 1, 0, CMD_SEND_ONE, 8'h00);
    step("rd3_stop", 1, 0, CMD_STOP, 8'h00);
    step("rd3_end", 1, 0, CMD_GET, 8'h00);
    check("rd3_data", bus.rd_data, 32'h00C3_B2A1);
    expect_done("rd3");

    // Slave NACKs the register byte on every attempt: two retries then error.
    done_snap = done_cnt;
    do_start("nack", 1'b0, 7'h1A, 8'h05, 3'd1, 32'h77);
    for (int a = 0; a <= RM; a++) begin
      step("nack_dev", 1, 0, CMD_SEND_BYTE, 8'h34);
      step("nack_reg", 1, 0, CMD_SEND_BYTE, 8'h05);
      step("nack_stop", 0, 1, CMD_STOP, 8'h00);
      if (a < RM)
        step("nack_retry", 1, 0, CMD_START, 8'h00);
    end
    step("nack_end", 1, 0, CMD_GET, 8'h00);
    check("nack_error", 32'(bus.error), 32'd1);
    check("nack_busy", 32'(bus.busy), 32'd0);
    tick();
    check("nack_err_pulse", 32'(bus.error), 32'd0);
    check("nack_no_done", 32'(done_cnt - done_snap), 32'd0);

    // One NACK arriving with req_next: STOP wins, the single retry then completes.
    err_snap = err_cnt;
    do_start("once", 1'b0, 7'h1A, 8'h05, 3'd1, 32'h77);
    step("once_dev", 1, 0, CMD_SEND_BYTE, 8'h34);
    step("once_both", 1, 1, CMD_STOP, 8'h00);
    step("once_retry", 1, 0, CMD_START, 8'h00);
    step("once_dev2", 1, 0, CMD_SEND_BYTE, 8'h34);
    step("once_reg", 1, 0, CMD_SEND_BYTE, 8'h05);
    step("once_d0", 1, 0, CMD_SEND_BYTE, 8'h77);
    step("once_stop", 1, 0, CMD_STOP, 8'h00);
    step("once_end", 1, 0, CMD_GET, 8'h00);
    expect_done("once");
    check("once_no_error", 32'(err_cnt - err_snap), 32'd0);

    // Pointer-set write with no data bytes.
    do_start("wr0", 1'b0, 7'h1A, 8'h05, 3'd0, 32'h0);
    step("wr0_dev", 1, 0, CMD_SEND_BYTE, 8'h34);
    step("wr0_reg", 1, 0, CMD_SEND_BYTE, 8'h05);
    step("wr0_stop", 1, 0, CMD_STOP, 8'h00);
    step("wr0_end", 1, 0, CMD_GET, 8'h00);
    expect_done("wr0");

    // Oversized read count is clamped to four RECV steps.
    do_start("rd7", 1'b1, 7'h1D, 8'h32, 3'd7, 32'h0);
    step("rd7_devw", 1, 0, CMD_SEND_BYTE, 8'h3A);
    step("rd7_reg", 1, 0, CMD_SEND_BYTE, 8'h32);
    step("rd7_rs", 1, 0, CMD_RSTART, 8'h00);
    step("rd7_devr", 1, 0, CMD_SEND_BYTE, 8'h3B);
    for (int i = 0; i < MB; i++) begin
      step("rd7_recv", 1, 0, CMD_RECV_BYTE, 8'h00);
      feed_rx(8'(8'h10 + i));
      step("rd7_ack", 1, 0, (i == MB - 1) ? CMD_SEND_ONE : CMD_SEND_ZERO, 8'h00);
    end
    step("rd7_stop", 1, 0, CMD_STOP, 8'h00);
    step("rd7_end", 1, 0, CMD_GET, 8'h00);
    check("rd7_data", bus.rd_data, 32'h1312_1110);
    expect_done("rd7");

    // Reset in the middle of a read.
    do_start("rdrst", 1'b1, 7'h1D, 8'h32, 3'd2, 32'h0);
    step("rdrst_devw", 1, 0, CMD_SEND_BYTE, 8'h3A);
    step("rdrst_reg", 1, 0, CMD_SEND_BYTE, 8'h32);
    step("rdrst_rs", 1, 0, CMD_RSTART, 8'h00);
    step("rdrst_devr", 1, 0, CMD_SEND_BYTE, 8'h3B);
    step("rdrst_r0", 1, 0, CMD_RECV_BYTE, 8'h00);
    feed_rx(8'h99);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rdrst_code", 32'(bus.send_next_state), 32'(CMD_GET));
    check("rdrst_busy", 32'(bus.busy), 32'd0);
    check("rdrst_rd", bus.rd_data, 32'h0);
    tick();
    check("rdrst_hold", 32'(bus.send_next_state), 32'(CMD_GET));

    check("done_error_overlap", 32'(both_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
